// File: rtl/ethernet_ipv4_handler.sv
// Byte-serial Ethernet II + IPv4 receive parser: captures MAC/IP header fields and forwards the IPv4 payload.
// Optional macro IPV4_CHECKSUM_CHECK_EN adds meta_checksum_ok (ones'-complement header checksum verification).
`ifndef INPUTWIDTH
`define INPUTWIDTH 8
`endif

module ethernet_ipv4_handler #(
  parameter int DATA_WIDTH = `INPUTWIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  meta_valid,
  output logic [47:0]           meta_dst_mac,
  output logic [47:0]           meta_src_mac,
  output logic [31:0]           meta_src_ip,
  output logic [31:0]           meta_dst_ip,
  output logic [7:0]            meta_protocol,
  output logic [15:0]           meta_total_length,
  output logic                  meta_ethertype_ok,
`ifdef IPV4_CHECKSUM_CHECK_EN
  output logic                  meta_checksum_ok,
`endif
  input  logic                  meta_ready
);

  typedef enum logic [1:0] {ETH_HDR, IP_HDR, PAYLOAD, DROP} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [15:0] pay_len;
  logic [15:0] pay_len_calc;
  logic [15:0] ethertype;
  logic [5:0]  hdr_len;
  logic [3:0]  ihl_eff;
  logic [4:0]  ci;
  logic [7:0]  din;
  logic        accept, meta_ack, hdr_last, pay_last;

  assign din           = s_axis_tdata[7:0];
  assign ci            = cnt[4:0];
  assign s_axis_tready = !meta_valid && (state != PAYLOAD || m_axis_tready || !m_axis_tvalid);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign meta_ack      = meta_valid && meta_ready;
  assign ihl_eff       = (din[3:0] < 4'd5) ? 4'd5 : din[3:0];
  assign hdr_last      = (cnt == {10'd0, hdr_len} - 16'd1);
  assign pay_len_calc  = meta_total_length - {10'd0, hdr_len};
  assign pay_last      = (cnt == pay_len - 16'd1);
  assign meta_ethertype_ok = (ethertype == 16'h0800);

`ifdef IPV4_CHECKSUM_CHECK_EN
  logic [15:0] csum;
  logic [7:0]  csum_hi;
  logic        csum_done;

  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  assign meta_checksum_ok = csum_done && (csum == 16'hFFFF);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ETH_HDR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (s_axis_tlast) begin
        state_nxt = ETH_HDR;
      end else begin
        case (state)
          ETH_HDR: if (cnt == 16'd13)
                     state_nxt = ({ethertype[15:8], din} == 16'h0800) ? IP_HDR : DROP;
          IP_HDR:  if (hdr_last)
                     state_nxt = (pay_len_calc == 16'd0) ? DROP : PAYLOAD;
          PAYLOAD: if (pay_last) state_nxt = DROP;
          default: state_nxt = state;
        endcase
      end
    end
  end

  // Header capture: fields are cleared when the record is accepted so truncated frames read 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt               <= '0;
      pay_len           <= '0;
      ethertype         <= '0;
      hdr_len           <= 6'd20;
      meta_valid        <= 1'b0;
      meta_dst_mac      <= '0;
      meta_src_mac      <= '0;
      meta_src_ip       <= '0;
      meta_dst_ip       <= '0;
      meta_protocol     <= '0;
      meta_total_length <= '0;
`ifdef IPV4_CHECKSUM_CHECK_EN
      csum              <= '0;
      csum_hi           <= '0;
      csum_done         <= 1'b0;
`endif
    end else begin
      if (meta_ack) begin
        meta_valid        <= 1'b0;
        ethertype         <= '0;
        hdr_len           <= 6'd20;
        meta_dst_mac      <= '0;
        meta_src_mac      <= '0;
        meta_src_ip       <= '0;
        meta_dst_ip       <= '0;
        meta_protocol     <= '0;
        meta_total_length <= '0;
`ifdef IPV4_CHECKSUM_CHECK_EN
        csum              <= '0;
        csum_hi           <= '0;
        csum_done         <= 1'b0;
`endif
      end
      if (accept) begin
        if (s_axis_tlast || state_nxt != state) cnt <= '0;
        else if (state != DROP)                 cnt <= cnt + 16'd1;
        case (state)
          ETH_HDR: begin
            if (cnt < 16'd6)        meta_dst_mac[8*(5 - ci) +: 8]  <= din;
            else if (cnt < 16'd12)  meta_src_mac[8*(11 - ci) +: 8] <= din;
            else if (cnt == 16'd12) ethertype[15:8] <= din;
            else                    ethertype[7:0]  <= din;
          end
          IP_HDR: begin
            if (cnt == 16'd0)       hdr_len <= {ihl_eff, 2'b00};
            if (cnt == 16'd2)       meta_total_length[15:8] <= din;
            if (cnt == 16'd3)       meta_total_length[7:0]  <= din;
            if (cnt == 16'd9)       meta_protocol <= din;
            if (cnt >= 16'd12 && cnt < 16'd16) meta_src_ip[8*(15 - ci) +: 8] <= din;
            if (cnt >= 16'd16 && cnt < 16'd20) meta_dst_ip[8*(19 - ci) +: 8] <= din;
            if (hdr_last)           pay_len <= pay_len_calc;
`ifdef IPV4_CHECKSUM_CHECK_EN
            if (!cnt[0]) csum_hi <= din;
            else         csum    <= ones_add(csum, {csum_hi, din});
            if (hdr_last) csum_done <= 1'b1;
`endif
          end
          default: ;
        endcase
        if (s_axis_tlast) meta_valid <= 1'b1;
      end
    end
  end

  // Payload output register: one-cycle latency, held until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
      if (accept && state == PAYLOAD) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= din;
        m_axis_tlast  <= pay_last || s_axis_tlast;
      end
    end
  end

endmodule

// File: tb/tb_ethernet_ipv4_handler.sv
// Self-checking bench for ethernet_ipv4_handler: random frames checked against a byte-level frame model.
module tb_ethernet_ipv4_handler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic        meta_valid, meta_ethertype_ok, meta_ready;
  logic [47:0] meta_dst_mac, meta_src_mac;
  logic [31:0] meta_src_ip, meta_dst_ip;
  logic [7:0]  meta_protocol;
  logic [15:0] meta_total_length;
`ifdef IPV4_CHECKSUM_CHECK_EN
  logic        meta_checksum_ok;
`endif

  always #5 clk = ~clk;

  ethernet_ipv4_handler dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .meta_valid(meta_valid), .meta_dst_mac(meta_dst_mac), .meta_src_mac(meta_src_mac),
    .meta_src_ip(meta_src_ip), .meta_dst_ip(meta_dst_ip), .meta_protocol(meta_protocol),
    .meta_total_length(meta_total_length), .meta_ethertype_ok(meta_ethertype_ok),
`ifdef IPV4_CHECKSUM_CHECK_EN
    .meta_checksum_ok(meta_checksum_ok),
`endif
    .meta_ready(meta_ready)
  );

  int vectors = 0;
  int errors  = 0;

  logic [7:0]  frame_q[$];
  logic [7:0]  exp_pay[$];
  logic [8:0]  mon_q[$];

  logic [47:0] e_dst, e_src;
  logic [15:0] e_et, e_tl, ip_id;
  logic [31:0] e_sip, e_dip;
  logic [7:0]  e_proto;
  bit          bad_csum;

  always @(negedge clk)
    if (rst_n && m_axis_tvalid && m_axis_tready) mon_q.push_back({m_axis_tlast, m_axis_tdata});

  // Frame model: Ethernet header, IPv4 header with options and checksum, payload, padding to 60, FCS
  task automatic build_frame(input int ihl, input int tl);
    int hl;
    int sum;
    logic [7:0]  h[60];
    logic [7:0]  b;
    logic [15:0] ck;
    hl = (ihl < 5 ? 5 : ihl) * 4;
    e_tl = 16'(tl);
    frame_q.delete();
    exp_pay.delete();
    for (int i = 0; i < 6; i++) frame_q.push_back(8'(e_dst >> (40 - 8 * i)));
    for (int i = 0; i < 6; i++) frame_q.push_back(8'(e_src >> (40 - 8 * i)));
    frame_q.push_back(8'(e_et >> 8));
    frame_q.push_back(8'(e_et));
    if (e_et == 16'h0800) begin
      for (int i = 0; i < 60; i++) h[i] = 8'($urandom);
      h[0] = 8'h40 | 8'(ihl & 15); h[1] = 8'h00;
      h[2] = 8'(tl >> 8);          h[3] = 8'(tl);
      h[4] = 8'(ip_id >> 8);       h[5] = 8'(ip_id);
      h[6] = 8'h00; h[7] = 8'h00;  h[8] = 8'd64; h[9] = e_proto;
      h[10] = 8'h00; h[11] = 8'h00;
      for (int i = 0; i < 4; i++) begin
        h[12 + i] = 8'(e_sip >> (24 - 8 * i));
        h[16 + i] = 8'(e_dip >> (24 - 8 * i));
      end
      sum = 0;
      for (int k = 0; k < hl; k += 2) sum += int'({h[k], h[k + 1]});
      while ((sum >> 16) != 0) sum = (sum & 'hFFFF) + (sum >> 16);
      ck = ~sum[15:0];
      if (!bad_csum) begin
        h[10] = ck[15:8];
        h[11] = ck[7:0];
      end
      for (int i = 0; i < hl; i++) frame_q.push_back(h[i]);
      for (int i = 0; i < tl - hl; i++) begin
        b = 8'($urandom);
        frame_q.push_back(b);
        exp_pay.push_back(b);
      end
    end else begin
      for (int i = 0; i < 46; i++) frame_q.push_back(8'($urandom));
    end
    while (frame_q.size() < 60) frame_q.push_back(8'h00);
    for (int i = 0; i < 4; i++) frame_q.push_back(8'($urandom));
  endtask

  task automatic randomize_fields();
    e_dst   = {$urandom, $urandom};
    e_src   = {$urandom, $urandom};
    e_sip   = $urandom;
    e_dip   = $urandom;
    e_proto = 8'h11;
    e_et    = 16'h0800;
    ip_id   = 16'($urandom);
    bad_csum = 1'b0;
  endtask

  task automatic send_frame(input int nbytes);
    int n;
    for (int i = 0; i < nbytes; i++) begin
      s_axis_tdata  = frame_q[i];
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == frame_q.size() - 1);
      n = 0;
      @(negedge clk);
      while (!s_axis_tready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!s_axis_tready) begin
        vectors++; errors++;
        $display("FAIL send_timeout: byte %0d tready=%b required 1", i, s_axis_tready);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_meta();
    int n = 0;
    while (!meta_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (meta_valid !== 1'b1) begin
      errors++;
      $display("FAIL meta_valid_timeout: got %b required 1", meta_valid);
    end
  endtask

  task automatic ack_meta();
    meta_ready = 1'b1;
    @(posedge clk);
    #1;
    meta_ready = 1'b0;
    vectors++;
    if (meta_valid !== 1'b0) begin
      errors++;
      $display("FAIL meta_ack_clear: got %b required 0", meta_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = 8'h00;
    m_axis_tready = 1'b1; meta_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({meta_valid, meta_dst_mac, meta_src_mac, meta_src_ip, meta_dst_ip, meta_protocol,
         meta_total_length, meta_ethertype_ok, m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: meta_valid=%b m_tvalid=%b m_tdata=%h required all 0",
               meta_valid, m_axis_tvalid, m_axis_tdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready: got %b required 1", s_axis_tready);
    end
  endtask

  task automatic test_udp_frames();
    int np;
    for (int f = 0; f < 10; f++) begin
      randomize_fields();
      build_frame(5, $urandom_range(40, 120));
      mon_q.delete();
      send_frame(frame_q.size());
      wait_meta();
      vectors++;
      if (meta_dst_mac !== e_dst || meta_src_mac !== e_src) begin
        errors++;
        $display("FAIL udp_macs: frame %0d got %h/%h required %h/%h", f, meta_dst_mac, meta_src_mac, e_dst, e_src);
      end
      vectors++;
      if (meta_src_ip !== e_sip || meta_dst_ip !== e_dip) begin
        errors++;
        $display("FAIL udp_ips: frame %0d got %h/%h required %h/%h", f, meta_src_ip, meta_dst_ip, e_sip, e_dip);
      end
      vectors++;
      if (meta_protocol !== e_proto || meta_total_length !== e_tl || meta_ethertype_ok !== 1'b1) begin
        errors++;
        $display("FAIL udp_proto_len: frame %0d got %h/%h/%b required %h/%h/1", f,
                 meta_protocol, meta_total_length, meta_ethertype_ok, e_proto, e_tl);
      end
      vectors++;
      if (s_axis_tready !== 1'b0) begin
        errors++;
        $display("FAIL udp_stall_while_meta: tready=%b required 0", s_axis_tready);
      end
      vectors++;
      if (mon_q.size() != exp_pay.size()) begin
        errors++;
        $display("FAIL udp_payload_count: frame %0d got %0d required %0d", f, mon_q.size(), exp_pay.size());
      end
      np = (mon_q.size() < exp_pay.size()) ? mon_q.size() : exp_pay.size();
      for (int i = 0; i < np; i++) begin
        vectors++;
        if (mon_q[i] !== {(i == exp_pay.size() - 1), exp_pay[i]}) begin
          errors++;
          $display("FAIL udp_payload_byte: frame %0d idx %0d got %h required %h", f, i, mon_q[i],
                   {(i == exp_pay.size() - 1), exp_pay[i]});
        end
      end
      ack_meta();
    end
  endtask

  task automatic test_non_ipv4();
    randomize_fields();
    e_et = 16'h86DD;
    build_frame(5, 40);
    mon_q.delete();
    send_frame(frame_q.size());
    wait_meta();
    vectors++;
    if (meta_ethertype_ok !== 1'b0) begin
      errors++;
      $display("FAIL v6_ethertype_ok: got %b required 0", meta_ethertype_ok);
    end
    vectors++;
    if (meta_dst_mac !== e_dst || meta_src_mac !== e_src) begin
      errors++;
      $display("FAIL v6_macs: got %h/%h required %h/%h", meta_dst_mac, meta_src_mac, e_dst, e_src);
    end
    vectors++;
    if (mon_q.size() != 0 || meta_src_ip !== 32'h0) begin
      errors++;
      $display("FAIL v6_no_payload: beats %0d src_ip %h required 0/0", mon_q.size(), meta_src_ip);
    end
    ack_meta();
  endtask

  task automatic test_ip_options();
    randomize_fields();
    build_frame(6, 28);
    mon_q.delete();
    send_frame(frame_q.size());
    wait_meta();
    vectors++;
    if (mon_q.size() != 4 || meta_dst_ip !== e_dip || meta_total_length !== 16'd28) begin
      errors++;
      $display("FAIL opt_summary: beats %0d dst_ip %h len %h required 4/%h/001c",
               mon_q.size(), meta_dst_ip, meta_total_length, e_dip);
    end
    for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
      vectors++;
      if (mon_q[i] !== {(i == 3), exp_pay[i]}) begin
        errors++;
        $display("FAIL opt_payload_byte: idx %0d got %h required %h", i, mon_q[i], {(i == 3), exp_pay[i]});
      end
    end
    ack_meta();
  endtask

`ifdef IPV4_CHECKSUM_CHECK_EN
  task automatic test_checksum();
    for (int k = 0; k < 2; k++) begin
      randomize_fields();
      e_sip = 32'hC0A80001; e_dip = 32'hC0A800C7; ip_id = 16'h1C46;
      bad_csum = (k == 1);
      build_frame(5, 60);
      send_frame(frame_q.size());
      wait_meta();
      vectors++;
      if (meta_checksum_ok !== (k == 0)) begin
        errors++;
        $display("FAIL checksum_ok: case %0d got %b required %b", k, meta_checksum_ok, (k == 0));
      end
      ack_meta();
    end
  endtask
`endif

  task automatic test_reset_mid_payload();
    randomize_fields();
    build_frame(5, 60);
    mon_q.delete();
    send_frame(14 + 20 + 5);
    vectors++;
    if (m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre_tvalid: got %b required 1", m_axis_tvalid);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, meta_valid, meta_dst_mac, meta_src_ip} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: m_tvalid=%b m_tdata=%h dst_mac=%h required 0",
               m_axis_tvalid, m_axis_tdata, meta_dst_mac);
    end
    @(negedge clk);
    rst_n = 1'b1;
    randomize_fields();
    build_frame(5, $urandom_range(40, 120));
    mon_q.delete();
    @(posedge clk);
    #1;
    send_frame(frame_q.size());
    wait_meta();
    vectors++;
    if (meta_dst_ip !== e_dip || meta_src_mac !== e_src || mon_q.size() != exp_pay.size()) begin
      errors++;
      $display("FAIL midrst_next_frame: dst_ip %h beats %0d required %h/%0d",
               meta_dst_ip, mon_q.size(), e_dip, exp_pay.size());
    end
    for (int i = 0; i < exp_pay.size() && i < mon_q.size(); i++) begin
      vectors++;
      if (mon_q[i][7:0] !== exp_pay[i]) begin
        errors++;
        $display("FAIL midrst_payload_byte: idx %0d got %h required %h", i, mon_q[i][7:0], exp_pay[i]);
      end
    end
    ack_meta();
  endtask

  initial begin
    test_reset();
    test_udp_frames();
    test_non_ipv4();
    test_ip_options();
`ifdef IPV4_CHECKSUM_CHECK_EN
    test_checksum();
`endif
    test_reset_mid_payload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
